// File: rtl/dmem_responder.sv
// dmem_responder
//   Memory-side responder for the hart's data-memory port. Accepts one load or
//   store at a time over a ready/valid handshake. It serves the request from an
//   internal word array after a fixed LATENCY, then returns a one-cycle
//   response strobe.
//
// Parameters
//   DEPTH_WORDS  number of 32-bit words (power of two)
//   LATENCY      cycles from acceptance edge to response (1..15)
//   BASE_ADDR    byte address mapped to word 0
//
// Ports
//   i_clk, i_rst_n   clock (rising edge), synchronous active-low reset
//   i_dmem_addr      byte address, word aligned
//   i_dmem_ren/wen   load / store request
//   i_dmem_wdata     store data in its byte lanes
//   i_dmem_mask      byte-lane enables
//   o_dmem_ready     request accepted on a rising edge while high
//   o_dmem_valid     one-cycle response strobe
//   o_dmem_rdata     load data, masked-off lanes zero
//   o_dmem_err       with valid: request was illegal and had no effect
module dmem_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned LATENCY     = 2,
    parameter logic [31:0] BASE_ADDR   = 32'h0
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [31:0] i_dmem_addr,
    input  logic        i_dmem_ren,
    input  logic        i_dmem_wen,
    input  logic [31:0] i_dmem_wdata,
    input  logic [3:0]  i_dmem_mask,
    output logic        o_dmem_ready,
    output logic        o_dmem_valid,
    output logic [31:0] o_dmem_rdata,
    output logic        o_dmem_err
);

    localparam int AW = $clog2(DEPTH_WORDS);
    // Counter holds LATENCY-1 at most. Keep at least one bit so LATENCY=1 still has a real register.
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(LATENCY - 1);
    // One past the last mapped byte. Computed in 33 bits so a window ending at 4 GiB does not wrap.
    localparam logic [32:0] END_ADDR = {1'b0, BASE_ADDR} + 33'(DEPTH_WORDS) * 33'd4;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [AW-1:0]   idx_q;
    logic [31:0]     wdata_q;
    logic [3:0]      mask_q;
    logic            wr_q;
    logic            err_q;

    logic [31:0]     mem [DEPTH_WORDS];

    logic            req;
    logic            req_err;
    logic [31:0]     addr_off;
    logic            fire;
    logic [31:0]     lane_en;

    assign req      = i_dmem_ren | i_dmem_wen;
    assign addr_off = i_dmem_addr - BASE_ADDR;
    assign req_err  = (i_dmem_addr[1:0] != 2'b00)
                    | (i_dmem_addr < BASE_ADDR)
                    | ({1'b0, i_dmem_addr} >= END_ADDR)
                    | (i_dmem_ren & i_dmem_wen);

    // The response edge: the last WAIT cycle with the counter drained.
    assign fire = (state == WAIT) && (cnt == '0);

    always_comb begin
        lane_en = '0;
        for (int b = 0; b < 4; b++) lane_en[8*b +: 8] = {8{mask_q[b]}};
    end

    assign o_dmem_ready = (state == IDLE);

    // The array has no reset. A reset edge never writes, so a reset in mid-flight drops the pending store.
    always_ff @(posedge i_clk) begin
        if (i_rst_n && fire && wr_q && !err_q) begin
            for (int b = 0; b < 4; b++)
                if (mask_q[b]) mem[idx_q][8*b +: 8] <= wdata_q[8*b +: 8];
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state        <= IDLE;
            cnt          <= '0;
            o_dmem_valid <= 1'b0;
            o_dmem_err   <= 1'b0;
            o_dmem_rdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req) begin
                        idx_q   <= AW'(addr_off >> 2);
                        wdata_q <= i_dmem_wdata;
                        mask_q  <= i_dmem_mask;
                        wr_q    <= i_dmem_wen;
                        err_q   <= req_err;
                        cnt     <= CNT_INIT;
                        state   <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt == '0) begin
                        state        <= RESP;
                        o_dmem_valid <= 1'b1;
                        o_dmem_err   <= err_q;
                        // Stores and errors return zero. Loads return the masked lanes.
                        o_dmem_rdata <= (err_q || wr_q) ? 32'h0 : (mem[idx_q] & lane_en);
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                RESP: begin
                    state        <= IDLE;
                    o_dmem_valid <= 1'b0;
                    o_dmem_err   <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] addr = '0;
    logic        ren = 1'b0;
    logic        wen = 1'b0;
    logic [31:0] wdata = '0;
    logic [3:0]  mask = '0;
    logic        ready, valid, err;
    logic [31:0] rdata;

    // Sweep instances: the requester holds a load of word 0 continuously.
    logic        s_ren = 1'b0;
    logic        rdy1, vld1, err1, rdy15, vld15, err15;
    logic [31:0] rd1, rd15;

    int checks = 0;
    int errors = 0;
    logic [32:0] sb[$];  // {err, rdata}

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(2), .BASE_ADDR(32'h0)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_dmem_addr(addr), .i_dmem_ren(ren),
        .i_dmem_wen(wen), .i_dmem_wdata(wdata), .i_dmem_mask(mask),
        .o_dmem_ready(ready), .o_dmem_valid(valid), .o_dmem_rdata(rdata), .o_dmem_err(err));

    dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(1), .BASE_ADDR(32'h0)) u_l1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_dmem_addr(32'h0), .i_dmem_ren(s_ren),
        .i_dmem_wen(1'b0), .i_dmem_wdata(32'h0), .i_dmem_mask(4'hF),
        .o_dmem_ready(rdy1), .o_dmem_valid(vld1), .o_dmem_rdata(rd1), .o_dmem_err(err1));

    dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(15), .BASE_ADDR(32'h0)) u_l15 (
        .i_clk(clk), .i_rst_n(rst_n), .i_dmem_addr(32'h0), .i_dmem_ren(s_ren),
        .i_dmem_wen(1'b0), .i_dmem_wdata(32'h0), .i_dmem_mask(4'hF),
        .o_dmem_ready(rdy15), .o_dmem_valid(vld15), .o_dmem_rdata(rd15), .o_dmem_err(err15));

    // Issue one request to the LATENCY=2 instance. Push the expected response, then pop it when valid shows.
    // Called and returns at #1 after an edge, with ready high.
    task automatic do_req(input string name, input logic r, input logic w,
                          input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] m, input logic [32:0] exp);
        int   low = 0;
        int   vat = -1;
        int   cyc;
        logic [32:0] e;
        ren = r; wen = w; addr = a; wdata = d; mask = m;
        sb.push_back(exp);
        @(posedge clk); #1;  // acceptance edge E0
        ren = 1'b0; wen = 1'b0; addr = 32'hX; wdata = 32'hX; mask = 4'hX;
        for (cyc = 0; cyc < 40; cyc++) begin
            if (valid) begin
                checks++;
                if (vat >= 0) begin
                    errors++; $display("FAIL %s valid_twice: at cycle %0d", name, cyc);
                end else if (sb.size() == 0) begin
                    errors++; $display("FAIL %s extra_valid: no response expected", name);
                end else begin
                    e = sb.pop_front();
                    if ({err, rdata} !== e) begin
                        errors++;
                        $display("FAIL %s data: got err=%b rdata=%h, want err=%b rdata=%h",
                                 name, err, rdata, e[32], e[31:0]);
                    end
                end
                vat = cyc;
            end
            if (ready) break;
            low++;
            @(posedge clk); #1;
        end
        checks++;
        if (cyc == 40) begin
            errors++; $display("FAIL %s timeout: ready never returned", name);
        end
        checks++;
        if (vat != 2) begin
            errors++; $display("FAIL %s latency: got %0d, want 2", name, vat);
        end
        checks++;
        if (low != 3) begin
            errors++; $display("FAIL %s ready_low: got %0d cycles, want 3", name, low);
        end
        if (sb.size() != 0) begin
            errors++; $display("FAIL %s scoreboard: %0d responses missing", name, sb.size());
            sb.delete();
        end
    endtask

    task automatic test_reset();
        logic [33:0] got;
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            got = {valid, err, rdata};
            checks++;
            if (got !== 34'h0) begin
                errors++; $display("FAIL reset_outputs: got valid=%b err=%b rdata=%h, want 0 0 0",
                                   valid, err, rdata);
            end
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (ready !== 1'b1) begin
            errors++; $display("FAIL reset_ready: got %b, want 1", ready);
        end
    endtask

    task automatic test_word();
        do_req("sw_word", 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, {1'b0, 32'h0});
        do_req("lw_word", 1'b1, 1'b0, 32'h10, 32'h0,       4'hF, {1'b0, 32'hDEADBEEF});
    endtask

    task automatic test_byte();
        do_req("sb_hi",   1'b0, 1'b1, 32'h10, 32'h11000000, 4'h8, {1'b0, 32'h0});
        do_req("lw_full", 1'b1, 1'b0, 32'h10, 32'h0,        4'hF, {1'b0, 32'h11ADBEEF});
        do_req("lw_lo16", 1'b1, 1'b0, 32'h10, 32'h0,        4'h3, {1'b0, 32'h0000BEEF});
    endtask

    task automatic test_mask0();
        do_req("sw_mask0", 1'b0, 1'b1, 32'h10, 32'hFFFFFFFF, 4'h0, {1'b0, 32'h0});
        do_req("lw_mask0", 1'b1, 1'b0, 32'h10, 32'h0,        4'h0, {1'b0, 32'h0});
        do_req("lw_after_mask0", 1'b1, 1'b0, 32'h10, 32'h0,  4'hF, {1'b0, 32'h11ADBEEF});
    endtask

    task automatic test_errors();
        do_req("sw_word0",  1'b0, 1'b1, 32'h0,    32'hA5A5A5A5, 4'hF, {1'b0, 32'h0});
        do_req("err_misal", 1'b0, 1'b1, 32'h12,   32'hFFFFFFFF, 4'hF, {1'b1, 32'h0});
        do_req("chk_misal", 1'b1, 1'b0, 32'h10,   32'h0,        4'hF, {1'b0, 32'h11ADBEEF});
        do_req("err_range", 1'b0, 1'b1, 32'h1000, 32'hFFFFFFFF, 4'hF, {1'b1, 32'h0});
        do_req("chk_range", 1'b1, 1'b0, 32'h0,    32'h0,        4'hF, {1'b0, 32'hA5A5A5A5});
        // Load error must also clear the previously returned nonzero data.
        do_req("err_range_ld", 1'b1, 1'b0, 32'h1000, 32'h0,     4'hF, {1'b1, 32'h0});
        do_req("err_both",  1'b1, 1'b1, 32'h10,   32'hFFFFFFFF, 4'hF, {1'b1, 32'h0});
        do_req("chk_both",  1'b1, 1'b0, 32'h10,   32'h0,        4'hF, {1'b0, 32'h11ADBEEF});
    endtask

    task automatic test_reset_mid();
        int seen = 0;
        do_req("sw_old", 1'b0, 1'b1, 32'h20, 32'hCAFEF00D, 4'hF, {1'b0, 32'h0});
        wen = 1'b1; addr = 32'h20; wdata = 32'h12345678; mask = 4'hF;
        @(posedge clk); #1;  // accepted
        wen = 1'b0;
        rst_n = 1'b0;
        @(posedge clk); #1;
        if (valid) seen++;
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (valid) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++; $display("FAIL reset_mid_valid: got %0d valid cycles, want 0", seen);
        end
        do_req("lw_old", 1'b1, 1'b0, 32'h20, 32'h0, 4'hF, {1'b0, 32'hCAFEF00D});
    endtask

    task automatic test_back_to_back(input int lat);
        logic prev_r, prev_v, r, v, e;
        int   acc = -1000;
        int   run = 0;
        int   nacc = 0;
        int   nval = 0;
        prev_r = (lat == 1) ? rdy1 : rdy15;
        prev_v = 1'b0;
        s_ren = 1'b1;
        for (int c = 0; c < 150; c++) begin
            @(posedge clk); #1;
            r = (lat == 1) ? rdy1 : rdy15;
            v = (lat == 1) ? vld1 : vld15;
            e = (lat == 1) ? err1 : err15;
            if (prev_r) begin acc = c; nacc++; end
            if (v) begin
                nval++;
                checks++;
                if (c - acc != lat || e !== 1'b0) begin
                    errors++; $display("FAIL b2b_L%0d latency: got %0d err=%b, want %0d err=0",
                                       lat, c - acc, e, lat);
                end
                checks++;
                if (prev_v) begin
                    errors++; $display("FAIL b2b_L%0d consecutive_valid: at cycle %0d", lat, c);
                end
            end
            if (!r) run++;
            else if (run > 0) begin
                checks++;
                if (run != lat + 1) begin
                    errors++; $display("FAIL b2b_L%0d ready_low: got %0d, want %0d", lat, run, lat + 1);
                end
                run = 0;
            end
            prev_r = r;
            prev_v = v;
        end
        checks++;
        if (nval < 3 || nacc < nval) begin
            errors++; $display("FAIL b2b_L%0d count: got %0d accepts %0d valids, want >=3 valids",
                               lat, nacc, nval);
        end
        s_ren = 1'b0;
        repeat (lat + 3) @(posedge clk);
        #1;
    endtask

    initial begin
        test_reset();
        test_word();
        test_byte();
        test_mask0();
        test_errors();
        test_reset_mid();
        test_back_to_back(1);
        test_back_to_back(15);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
